sobel_window_reader: RTL and testbench

SOBEL_WINDOW_READER -- requirements
Module: sobel_window_reader

---
 rtl/sobel_pkg.sv | 24 ++
 rtl/window_row_shift.sv | 28 ++
 rtl/sobel_window_reader.sv | 146 ++++++++++++++
 tb/tb_sobel_window_reader.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel window reader: default pixel
// width, FSM state encoding and 3x3 window slot indices (row-major, P00 first).
package sobel_pkg;

    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        ACTIVE,
        DONE
    } sobelStateT;

    localparam int unsigned P00 = 0;
    localparam int unsigned P01 = 1;
    localparam int unsigned P02 = 2;
    localparam int unsigned P10 = 3;
    localparam int unsigned P11 = 4;
    localparam int unsigned P12 = 5;
    localparam int unsigned P20 = 6;
    localparam int unsigned P21 = 7;
    localparam int unsigned P22 = 8;

endpackage

// File: rtl/window_row_shift.sv
// One row of the 3x3 window: a 3-deep, Enable-gated shift register.
// Tap0 is the oldest pixel (left column), Tap2 the newest (right column).
module window_row_shift #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Enable,
    input  logic [DATA_W-1:0] DataIn,
    output logic [DATA_W-1:0] Tap0,
    output logic [DATA_W-1:0] Tap1,
    output logic [DATA_W-1:0] Tap2
);

    // shift left by one column on each pixel strobe
    always_ff @(posedge CLK) begin
        if (Reset) begin
            Tap0 <= '0;
            Tap1 <= '0;
            Tap2 <= '0;
        end else if (Enable) begin
            Tap0 <= Tap1;
            Tap1 <= Tap2;
            Tap2 <= DataIn;
        end
    end

endmodule

// File: rtl/sobel_window_reader.sv
// Sobel 3x3 window reader: assembles a 3x3 neighbourhood from the three
// line-buffer taps, tracks the pixel position and flags in-frame windows.
// Optional feature: define SOBEL_WIN_COUNT_EN to add the WinCount output.
module sobel_window_reader
    import sobel_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic                Enable,
    input  logic [DATA_W-1:0]   Row0In,
    input  logic [DATA_W-1:0]   Row1In,
    input  logic [DATA_W-1:0]   Row2In,
    output logic [9*DATA_W-1:0] Window,
    output logic                WindowValid,
    output logic                FrameDone,
`ifdef SOBEL_WIN_COUNT_EN
    output logic [15:0]         WinCount,
`endif
    output logic                Busy
);

    localparam int unsigned COL_W = $clog2(IMG_WIDTH);
    localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);

    sobelStateT       state;
    sobelStateT       stateNext;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             validReg;
    logic             lastCol;
    logic             lastRow;
    logic             inFrame;

    assign lastCol = (col == COL_W'(IMG_WIDTH - 1));
    assign lastRow = (row == ROW_W'(IMG_HEIGHT - 1));
    assign inFrame = (row >= ROW_W'(2)) && (col >= COL_W'(2));

    window_row_shift #(.DATA_W(DATA_W)) uRow0 (
        .CLK    (CLK),
        .Reset  (Reset),
        .Enable (Enable),
        .DataIn (Row0In),
        .Tap0   (Window[P00*DATA_W +: DATA_W]),
        .Tap1   (Window[P01*DATA_W +: DATA_W]),
        .Tap2   (Window[P02*DATA_W +: DATA_W])
    );

    window_row_shift #(.DATA_W(DATA_W)) uRow1 (
        .CLK    (CLK),
        .Reset  (Reset),
        .Enable (Enable),
        .DataIn (Row1In),
        .Tap0   (Window[P10*DATA_W +: DATA_W]),
        .Tap1   (Window[P11*DATA_W +: DATA_W]),
        .Tap2   (Window[P12*DATA_W +: DATA_W])
    );

    window_row_shift #(.DATA_W(DATA_W)) uRow2 (
        .CLK    (CLK),
        .Reset  (Reset),
        .Enable (Enable),
        .DataIn (Row2In),
        .Tap0   (Window[P20*DATA_W +: DATA_W]),
        .Tap1   (Window[P21*DATA_W +: DATA_W]),
        .Tap2   (Window[P22*DATA_W +: DATA_W])
    );

    // column/row position of the next pixel; the last pixel of a frame wraps
    // both to zero, which is exactly the clear on entry to DONE
    always_ff @(posedge CLK) begin
        if (Reset) begin
            col <= '0;
            row <= '0;
        end else if (Enable) begin
            if (lastCol) begin
                col <= '0;
                row <= lastRow ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // window-complete flag, updated per pixel and held across Enable-low gaps
    always_ff @(posedge CLK) begin
        if (Reset || state == DONE) begin
            validReg <= 1'b0;
        end else if (Enable) begin
            validReg <= inFrame;
        end
    end

    // FSM state register
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // FSM next state and outputs; Valid is presented only on strobe cycles so
    // a held window is reported once, except DONE which flags the final window
    always_comb begin
        stateNext   = state;
        FrameDone   = 1'b0;
        Busy        = 1'b0;
        WindowValid = validReg & Enable;
        unique case (state)
            IDLE: begin
                if (Enable) stateNext = PRIME;
            end
            PRIME: begin
                Busy = 1'b1;
                if (Enable && row == ROW_W'(2) && col == '0) stateNext = ACTIVE;
            end
            ACTIVE: begin
                Busy = 1'b1;
                if (Enable && lastRow && lastCol) stateNext = DONE;
            end
            DONE: begin
                FrameDone   = 1'b1;
                WindowValid = 1'b1;
                stateNext   = Enable ? PRIME : IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

`ifdef SOBEL_WIN_COUNT_EN
    // counts windows as they are captured, so the final window is already
    // included while FrameDone is high; cleared by the DONE cycle
    always_ff @(posedge CLK) begin
        if (Reset || state == DONE) begin
            WinCount <= '0;
        end else if (Enable && inFrame && WinCount != '1) begin
            WinCount <= WinCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sobel_window_reader.sv
// Directed bench for sobel_window_reader on a 4x4, 8-bit frame.
// Pixel values follow a global stream counter, so line-buffer taps are
// modelled as the stream value 4 and 8 pixels earlier.
module tb_sobel_window_reader;

    localparam int unsigned DW = 8;
    localparam int unsigned W  = 4;
    localparam int unsigned H  = 4;

    logic            CLK;
    logic            Reset;
    logic            Enable;
    logic [DW-1:0]   Row0In;
    logic [DW-1:0]   Row1In;
    logic [DW-1:0]   Row2In;
    logic [9*DW-1:0] Window;
    logic            WindowValid;
    logic            FrameDone;
    logic            Busy;
`ifdef SOBEL_WIN_COUNT_EN
    logic [15:0]     WinCount;
`endif

    int total = 0;
    int bad   = 0;
    int stream = 0;
    int winSeen = 0;
    int fdSeen = 0;
    int winBase;
    int fdBase;
    logic [71:0] expQ[$];
    logic [71:0] seenQ[$];

    sobel_window_reader #(
        .DATA_W     (DW),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .Enable      (Enable),
        .Row0In      (Row0In),
        .Row1In      (Row1In),
        .Row2In      (Row2In),
        .Window      (Window),
        .WindowValid (WindowValid),
        .FrameDone   (FrameDone),
`ifdef SOBEL_WIN_COUNT_EN
        .WinCount    (WinCount),
`endif
        .Busy        (Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkVal(input string tag, input logic [71:0] got, input logic [71:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // drive one pixel (frame-relative index p) and queue its window if in-frame
    task automatic pushPixel(input int p);
        logic [71:0] e;
        e = '0;
        Enable = 1'b1;
        Row2In = 8'(stream);
        Row1In = 8'(stream - 4);
        Row0In = 8'(stream - 8);
        if ((p / 4) >= 2 && (p % 4) >= 2) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    e[8*(3*r+c) +: 8] = 8'(stream - 10 + 4*r + c);
            expQ.push_back(e);
        end
        stream++;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        Enable = 1'b0;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // output monitor: window contents, pulse counts, no Valid on idle cycles
    initial begin
        logic [71:0] e;
        forever begin
            @(negedge CLK);
            if (WindowValid) begin
                winSeen++;
                seenQ.push_back(Window);
                e = (expQ.size() > 0) ? expQ.pop_front() : '1;
                checkVal("window", Window, e);
            end
            if (FrameDone) fdSeen++;
            if (!Enable && !FrameDone && !Reset)
                checkVal("validWhileIdle", WindowValid, 0);
        end
    end

    initial begin
        Reset  = 1'b1;
        Enable = 1'b0;
        Row0In = '0;
        Row1In = '0;
        Row2In = '0;
        repeat (2) @(posedge CLK);
        #1;
        checkVal("rstWindow", Window, 0);
        checkVal("rstValid", WindowValid, 0);
        checkVal("rstFrameDone", FrameDone, 0);
        checkVal("rstBusy", Busy, 0);
        Reset = 1'b0;
        idle(1);

        // continuous frame, pixels 00..0F
        winBase = winSeen;
        fdBase  = fdSeen;
        pushPixel(0);
        checkVal("busyAfterFirst", Busy, 1);
        for (int p = 1; p < 16; p++) pushPixel(p);
        Enable = 1'b0;
        checkVal("frameDoneAfterLast", FrameDone, 1);
`ifdef SOBEL_WIN_COUNT_EN
        checkVal("winCountAtDone", WinCount, 4);
`endif
        idle(1);
        checkVal("frameDonePulse", FrameDone, 0);
        checkVal("busyAfterFrame", Busy, 0);
`ifdef SOBEL_WIN_COUNT_EN
        checkVal("winCountCleared", WinCount, 0);
`endif
        idle(2);
        checkVal("contWinCount", winSeen - winBase, 4);
        checkVal("contFdCount", fdSeen - fdBase, 1);
        checkVal("firstWindow", (seenQ.size() > 0) ? seenQ[0] : '0, 72'h0A0908_060504_020100);

        // same frame shape with Enable low every other cycle
        winBase = winSeen;
        fdBase  = fdSeen;
        for (int p = 0; p < 16; p++) begin
            pushPixel(p);
            idle(1);
        end
        idle(2);
        checkVal("altWinCount", winSeen - winBase, 4);
        checkVal("altFdCount", fdSeen - fdBase, 1);

        // reset part-way through a frame
        for (int p = 0; p < 10; p++) pushPixel(p);
        Enable = 1'b0;
        Reset  = 1'b1;
        @(posedge CLK);
        #1;
        Reset = 1'b0;
        checkVal("midRstWindow", Window, 0);
        checkVal("midRstValid", WindowValid, 0);
        checkVal("midRstFrameDone", FrameDone, 0);
        checkVal("midRstBusy", Busy, 0);
        winBase = winSeen;
        fdBase  = fdSeen;
        for (int p = 0; p < 16; p++) pushPixel(p);
        idle(3);
        checkVal("postRstWinCount", winSeen - winBase, 4);
        checkVal("postRstFdCount", fdSeen - fdBase, 1);

        // back-to-back frames, next frame's first pixel lands in DONE
        winBase = winSeen;
        fdBase  = fdSeen;
        for (int k = 0; k < 32; k++) pushPixel(k % 16);
        idle(3);
        checkVal("b2bWinCount", winSeen - winBase, 8);
        checkVal("b2bFdCount", fdSeen - fdBase, 2);
        checkVal("b2bSecondFirstWin", (seenQ.size() > 16) ? seenQ[16] : '0,
                 72'h545352_504F4E_4C4B4A);
        checkVal("expQueueDrained", expQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
